// File: rtl/branch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared opcode / REGIMM rt codes, FSM state encoding and the branch
// condition helper used by branch_ctrl.
// -----------------------------------------------------------------------------
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DS   = 2'd2
  } state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;  // JR / JALR
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_BEQL    = 6'h14;
  localparam logic [5:0] OP_BNEL    = 6'h15;
  localparam logic [5:0] OP_BLEZL   = 6'h16;
  localparam logic [5:0] OP_BGTZL   = 6'h17;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  // Conditional-branch outcome from comparator flags of a=rs, b=rt.
  function automatic logic branch_cond(
    input logic [5:0] op,
    input logic [4:0] rt,
    input logic       eq,
    input logic       a_zero,
    input logic       a_neg
  );
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQ:    t = eq;
      OP_BNE:    t = !eq;
      OP_BLEZ:   t = a_neg | a_zero;
      OP_BGTZ:   t = !a_neg & !a_zero;
      OP_REGIMM: begin
        case (rt)
          RT_BGEZ, RT_BGEZAL: t = !a_neg;
          RT_BLTZ, RT_BLTZAL: t = a_neg;
          default:            t = 1'b0;
        endcase
      end
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_ctrl_eqcmp.sv
// -----------------------------------------------------------------------------
// branch_ctrl_eqcmp
// Operand comparator for branch resolution.
// Ports:
//   i_a, i_b  : operands (rs, rt)
//   o_eq      : i_a == i_b
//   o_a_zero  : i_a == 0
//   o_a_neg   : i_a sign bit
// -----------------------------------------------------------------------------
module branch_ctrl_eqcmp #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_a_zero,
  output logic         o_a_neg
);

  assign o_eq     = (i_a == i_b);
  assign o_a_zero = (i_a == '0);
  assign o_a_neg  = i_a[W-1];

endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// ID-stage branch/jump controller with one architectural delay slot.
// Resolves conditional branches and jumps, stalls IF/ID while operands are
// pending, redirects fetch once the delay-slot instruction leaves ID, and
// issues the link-register write request.
//
// Optional feature: define BRANCH_LIKELY_EN to resolve BEQL/BNEL/BLEZL/BGTZL
// and annul the delay slot when they fall through. Without it those opcodes
// are ordinary instructions and annul_ds is held 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid, id_is_branch,
//   id_is_jump, id_op, id_rt,
//   id_link                  decoded ID instruction
//   rs_val, rt_val,
//   opnd_ready               forwarded operands and their readiness
//   id_pc, id_imm, id_jtarget
//                            PC, branch offset, jump target
//   pipe_stall, flush        downstream stall, exception flush
//   stall_req                hold IF/ID while operands pending
//   pc_redirect, redirect_pc fetch redirect
//   in_delay_slot            ID instruction is a delay slot
//   link_we, link_addr       link register write request
//   annul_ds                 kill the delay-slot instruction
// -----------------------------------------------------------------------------
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_is_branch,
  input  logic              id_is_jump,
  input  logic [5:0]        id_op,
  input  logic [4:0]        id_rt,
  input  logic              id_link,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic              opnd_ready,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [15:0]       id_imm,
  input  logic [ADDR_W-1:0] id_jtarget,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              stall_req,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              in_delay_slot,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              annul_ds
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_taken;
  logic [ADDR_W-1:0]   r_target;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_link_pend;

  logic                w_eq;
  logic                w_a_zero;
  logic                w_a_neg;
  logic                w_likely_op;
  logic                w_is_cti;
  logic [5:0]          w_base_op;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_pc_base;
  logic [ADDR_W-1:0]   w_br_off;
  logic [ADDR_W-1:0]   w_br_tgt;
  logic [ADDR_W-1:0]   w_target;
  logic                w_accept;
  logic                w_resolve;

  branch_ctrl_eqcmp #(
    .W (32)
  ) u_eqcmp (
    .i_a      (rs_val),
    .i_b      (rt_val),
    .o_eq     (w_eq),
    .o_a_zero (w_a_zero),
    .o_a_neg  (w_a_neg)
  );

  assign w_likely_op = (id_op >= OP_BEQL) && (id_op <= OP_BGTZL);

`ifdef BRANCH_LIKELY_EN
  logic r_likely;
  // Likely forms share the base-form condition: 0x14..0x17 -> 0x04..0x07.
  assign w_base_op = w_likely_op ? {2'b00, id_op[3:0]} : id_op;
  assign w_is_cti  = id_is_branch | id_is_jump | w_likely_op;
`else
  assign w_base_op = id_op;
  assign w_is_cti  = (id_is_branch | id_is_jump) & !w_likely_op;
`endif

  assign w_taken = id_is_jump ? 1'b1
                 : branch_cond(w_base_op, id_rt, w_eq, w_a_zero, w_a_neg);

  // While waiting for operands the target is rebuilt from the captured PC.
  assign w_pc_base = (r_state == ST_WAIT) ? r_pc : id_pc;
  assign w_br_off  = {{(ADDR_W-18){id_imm[15]}}, id_imm, 2'b00};
  assign w_br_tgt  = w_pc_base + ADDR_W'(4) + w_br_off;
  assign w_target  = !id_is_jump          ? w_br_tgt
                   : (id_op == OP_SPECIAL) ? ADDR_W'(rs_val)
                   :                         id_jtarget;

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_resolve     = 1'b0;
    stall_req     = 1'b0;
    pc_redirect   = 1'b0;
    redirect_pc   = '0;
    in_delay_slot = 1'b0;
    link_we       = 1'b0;
    link_addr     = '0;
    annul_ds      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (id_valid && w_is_cti) begin
          stall_req = !opnd_ready;
          if (!pipe_stall) begin
            w_accept    = 1'b1;
            w_resolve   = opnd_ready;
            w_state_nxt = opnd_ready ? ST_DS : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_req = !opnd_ready;
        if (opnd_ready && !pipe_stall) begin
          w_resolve   = 1'b1;
          w_state_nxt = ST_DS;
        end
      end
      ST_DS: begin
        in_delay_slot = 1'b1;
        // Link pulse waits out a stall so it fires exactly once.
        link_we = r_link_pend && !pipe_stall;
        if (link_we) begin
          link_addr = r_pc + ADDR_W'(8);
        end
        if (id_valid && !pipe_stall) begin
          pc_redirect = r_taken;
          if (r_taken) begin
            redirect_pc = r_target;
          end
`ifdef BRANCH_LIKELY_EN
          annul_ds = r_likely && !r_taken;
`endif
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (flush) begin
      w_state_nxt   = ST_IDLE;
      w_accept      = 1'b0;
      w_resolve     = 1'b0;
      stall_req     = 1'b0;
      pc_redirect   = 1'b0;
      redirect_pc   = '0;
      in_delay_slot = 1'b0;
      link_we       = 1'b0;
      link_addr     = '0;
      annul_ds      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_pc        <= '0;
      r_link_pend <= 1'b0;
`ifdef BRANCH_LIKELY_EN
      r_likely    <= 1'b0;
`endif
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_taken     <= 1'b0;
      r_link_pend <= 1'b0;
`ifdef BRANCH_LIKELY_EN
      r_likely    <= 1'b0;
`endif
    end else if (!pipe_stall) begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pc <= id_pc;
      end
      if (w_resolve) begin
        r_taken     <= w_taken;
        r_target    <= w_target;
        r_link_pend <= id_link;
`ifdef BRANCH_LIKELY_EN
        r_likely    <= w_likely_op;
`endif
      end else if (r_state == ST_DS) begin
        r_link_pend <= 1'b0;
      end
    end
  end

endmodule
